lc3_operate_unit: RTL and testbench

LC3_OPERATE_UNIT -- requirements
Module: lc3_operate_unit

---
 rtl/lc3_pkg.sv | 34 +++
 rtl/lc3_alu.sv | 23 ++
 rtl/lc3_operate_unit.sv | 98 +++++++++
 tb/tb_lc3_operate_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 operate unit: opcodes, FSM states, condition codes.
// Latency: n/a (package). Backpressure: n/a.
// Helper functions classify opcodes and derive one-hot NZP from a result.
package lc3_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    function automatic logic is_operate(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15])
            return NZP_N;
        else if (v == 16'h0000)
            return NZP_Z;
        else
            return NZP_P;
    endfunction

endpackage

// File: rtl/lc3_alu.sv
// Combinational ADD/AND/NOT datapath for LC-3 operate instructions.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Unknown opcodes yield zero; the caller never commits them.
module lc3_alu
    import lc3_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  op,
    output logic [15:0] result
);

    always_comb begin
        result = 16'h0000;
        case (op)
            OP_ADD:  result = a + b;
            OP_AND:  result = a & b;
            OP_NOT:  result = ~a;
            default: result = 16'h0000;
        endcase
    end

endmodule

// File: rtl/lc3_operate_unit.sv
// Executes one LC-3 ADD/AND/NOT per accepted word and writes the register file.
// Latency: write/done in the 4th cycle after acceptance; illegal flagged in the 2nd.
// Backpressure: instr_ready only in IDLE, so at most one instruction per 4 cycles.
module lc3_operate_unit
    import lc3_pkg::*;
#(
    parameter logic [2:0] NZP_RST = 3'b010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  rf_sr1,
    output logic [2:0]  rf_sr2,
    input  logic [15:0] rf_sr1_data,
    input  logic [15:0] rf_sr2_data,
    output logic [2:0]  rf_dr,
    output logic [15:0] rf_d,
    output logic        rf_we,
    output logic [2:0]  nzp,
    output logic        done,
    output logic        illegal
);

    state_t      state_q;
    logic [15:0] ir_q;
    logic [15:0] result_q;
    logic [15:0] result_d;
    logic [15:0] op_b;
    logic [2:0]  nzp_q;
    logic        we_q;
    logic        done_q;
    logic        illegal_q;

    assign op_b = ir_q[5] ? {{11{ir_q[4]}}, ir_q[4:0]} : rf_sr2_data;

    lc3_alu u_alu (
        .a      (rf_sr1_data),
        .b      (op_b),
        .op     (ir_q[15:12]),
        .result (result_d)
    );

    // Pulses are registered one edge ahead so they line up with the state they belong to;
    // nzp is loaded with the result so it is already valid while the write is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ir_q      <= 16'h0000;
            result_q  <= 16'h0000;
            nzp_q     <= NZP_RST;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        ir_q      <= instr;
                        illegal_q <= !is_operate(instr[15:12]);
                        state_q   <= DECODE;
                    end
                end
                DECODE: begin
                    state_q <= is_operate(ir_q[15:12]) ? EXEC : IDLE;
                end
                EXEC: begin
                    result_q <= result_d;
                    nzp_q    <= nzp_of(result_d);
                    we_q     <= 1'b1;
                    done_q   <= 1'b1;
                    state_q  <= WB;
                end
                WB: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign rf_sr1      = ir_q[8:6];
    assign rf_sr2      = ir_q[2:0];
    assign rf_dr       = ir_q[11:9];
    assign rf_d        = result_q;
    assign rf_we       = we_q;
    assign nzp         = nzp_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_lc3_operate_unit.sv
// Bench for lc3_operate_unit: register-file model, timeline reference model, directed and random stimulus.
`timescale 1ns/1ps
module tb_lc3_operate_unit;

    localparam logic [2:0] NZP_RST = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_ready;
    logic [2:0]  rf_sr1, rf_sr2, rf_dr, nzp;
    logic [15:0] rf_sr1_data, rf_sr2_data, rf_d;
    logic        rf_we, done, illegal;

    logic [15:0] regs [8];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_idx = 3'd0;
    logic [15:0] pl_val = 16'h0000;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lc3_operate_unit #(.NZP_RST(NZP_RST)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_sr1      (rf_sr1),
        .rf_sr2      (rf_sr2),
        .rf_sr1_data (rf_sr1_data),
        .rf_sr2_data (rf_sr2_data),
        .rf_dr       (rf_dr),
        .rf_d        (rf_d),
        .rf_we       (rf_we),
        .nzp         (nzp),
        .done        (done),
        .illegal     (illegal)
    );

    // Register file: combinational read, write at the clock edge.
    assign rf_sr1_data = regs[rf_sr1];
    assign rf_sr2_data = regs[rf_sr2];
    always @(posedge clk) begin
        if (rf_we)
            regs[rf_dr] <= rf_d;
        else if (pl_en)
            regs[pl_idx] <= pl_val;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", nm, got, want, $time);
        end
    endtask

    // ---------------- reference model (instruction timeline) ----------------
    function automatic logic legal_op(input logic [15:0] w);
        return (w[15:12] == 4'h1) || (w[15:12] == 4'h5) || (w[15:12] == 4'h9);
    endfunction

    function automatic logic [15:0] eval_op(input logic [15:0] w, input logic [15:0] a, input logic [15:0] r2);
        logic [15:0] b;
        b = w[5] ? 16'($signed(w[4:0])) : r2;
        case (w[15:12])
            4'h1:    return a + b;
            4'h5:    return a & b;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [2:0] flags_of(input logic [15:0] r);
        if ($signed(r) < 0) return 3'b100;
        if (r == 16'h0000)  return 3'b010;
        return 3'b001;
    endfunction

    int          cyc = 0;
    int          next_acc = 0;
    int          wb_edge = -1;
    logic        started = 1'b0;
    logic [15:0] m_ir = 16'h0000;
    logic [2:0]  m_nzp = NZP_RST;
    logic        exp_ready = 1'b1, exp_we = 1'b0, exp_done = 1'b0, exp_ill = 1'b0;
    logic [15:0] exp_d = 16'h0000, pend_d = 16'h0000;
    logic [2:0]  pend_nzp = 3'b000;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            exp_we   = 1'b0;
            exp_done = 1'b0;
            exp_ill  = 1'b0;
            if (rst) begin
                started  = 1'b1;
                m_ir     = 16'h0000;
                m_nzp    = NZP_RST;
                next_acc = cyc + 1;
                wb_edge  = -1;
            end else begin
                if (cyc == wb_edge) begin
                    exp_we   = 1'b1;
                    exp_done = 1'b1;
                    exp_d    = pend_d;
                    m_nzp    = pend_nzp;
                end
                if (cyc >= next_acc && instr_valid) begin
                    m_ir = instr;
                    if (legal_op(instr)) begin
                        pend_d   = eval_op(instr, regs[instr[8:6]], regs[instr[2:0]]);
                        pend_nzp = flags_of(pend_d);
                        wb_edge  = cyc + 2;
                        next_acc = cyc + 4;
                    end else begin
                        exp_ill  = 1'b1;
                        next_acc = cyc + 2;
                    end
                end
            end
            exp_ready = (cyc + 1 >= next_acc);
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("ready", instr_ready, exp_ready);
                chk("rf_we", rf_we, exp_we);
                chk("done", done, exp_done);
                chk("illegal", illegal, exp_ill);
                chk("nzp", nzp, m_nzp);
                chk("rf_sr1", rf_sr1, m_ir[8:6]);
                chk("rf_sr2", rf_sr2, m_ir[2:0]);
                chk("rf_dr", rf_dr, m_ir[11:9]);
                if (exp_we)
                    chk("rf_d", rf_d, exp_d);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_reg(input logic [2:0] idx, input logic [15:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        step();
        pl_en  = 1'b0;
    endtask

    task automatic issue(input logic [15:0] w, input logic [15:0] want_d, input logic [2:0] want_nzp,
                         input logic [2:0] want_dr, input string nm);
        int n;
        instr       = w;
        instr_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) instr_valid = 1'b0;
        end while (!rf_we && n < 8);
        chk({nm, "_latency"}, n, 3);
        chk({nm, "_d"}, rf_d, want_d);
        chk({nm, "_nzp"}, nzp, want_nzp);
        chk({nm, "_dr"}, rf_dr, want_dr);
        chk({nm, "_done"}, done, 1'b1);
        step();
    endtask

    initial begin
        int nd;
        rst = 1'b1;
        for (int i = 0; i < 8; i++)
            set_reg(3'(i), 16'($urandom));
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_nzp", nzp, 3'b010);
        rst = 1'b0;
        step();
        chk("post_rst_ready", instr_ready, 1'b1);

        set_reg(3'd1, 16'd5);
        set_reg(3'd2, 16'd7);
        issue(16'h1642, 16'h000C, 3'b001, 3'd3, "add_rr");
        set_reg(3'd0, 16'h0000);
        issue(16'h103F, 16'hFFFF, 3'b100, 3'd0, "add_imm_neg");
        set_reg(3'd5, 16'h00FF);
        issue(16'h997F, 16'hFF00, 3'b100, 3'd4, "not");
        set_reg(3'd2, 16'h1234);
        issue(16'h54A0, 16'h0000, 3'b010, 3'd2, "and_zero");
        issue(16'h1241, 16'h000A, 3'b001, 3'd1, "add_dr_eq_sr");
        issue(16'h1261, 16'h000B, 3'b001, 3'd1, "add_after_write");

        // illegal opcode: flag in the decode cycle, nothing written, nzp kept
        instr = 16'h0000;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("ill_pulse", illegal, 1'b1);
        chk("ill_we", rf_we, 1'b0);
        chk("ill_nzp", nzp, 3'b001);
        step();
        chk("ill_pulse_end", illegal, 1'b0);
        chk("ill_ready_after", instr_ready, 1'b1);

        // reset during EXEC aborts the write
        instr = 16'h1642;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_nzp", nzp, NZP_RST);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rf_we) nd++;
        end
        chk("abort_no_write", nd, 0);

        // valid held high: only every 4th cycle accepted
        nd = 0;
        instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            instr = {(i % 2 == 0) ? 4'h1 : 4'h5, 12'($urandom)};
            step();
            if (done) nd++;
        end
        instr_valid = 1'b0;
        chk("b2b_done_count", nd, 3);
        repeat (4) step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [3:0] op;
            case ($urandom_range(0, 3))
                0:       op = 4'h1;
                1:       op = 4'h5;
                2:       op = 4'h9;
                default: op = 4'($urandom);
            endcase
            rst         = ($urandom_range(0, 63) == 0);
            instr_valid = ($urandom_range(0, 2) != 0);
            instr       = {op, 12'($urandom)};
            step();
        end
        rst = 1'b0;
        instr_valid = 1'b0;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
